// File: rtl/dmemory_io_multi_pkg.sv
// ============================================================================
//  Module  : dmem_io_pkg (package)
//  Purpose : Shared register offsets and 7-segment patterns for the
//            dmemory_io_multi data-memory / memory-mapped I/O block.
//  Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

package dmem_io_pkg;

  // Register offsets relative to IO_BASE
  localparam int SW_STAT_OFS = 0;
  localparam int SW_EVT_OFS  = 1;
  localparam int DISP_OFS    = 2;
  localparam int TIMER_OFS   = 8;
  localparam int TCTRL_OFS   = 9;

  // Segment patterns {g,f,e,d,c,b,a}, active-high
  localparam logic [6:0] SEG7_0 = 7'h3F;
  localparam logic [6:0] SEG7_1 = 7'h06;
  localparam logic [6:0] SEG7_2 = 7'h5B;
  localparam logic [6:0] SEG7_3 = 7'h4F;
  localparam logic [6:0] SEG7_4 = 7'h66;
  localparam logic [6:0] SEG7_5 = 7'h6D;
  localparam logic [6:0] SEG7_6 = 7'h7D;
  localparam logic [6:0] SEG7_7 = 7'h07;
  localparam logic [6:0] SEG7_8 = 7'h7F;
  localparam logic [6:0] SEG7_9 = 7'h6F;
  localparam logic [6:0] SEG7_A = 7'h77;
  localparam logic [6:0] SEG7_B = 7'h7C;
  localparam logic [6:0] SEG7_C = 7'h39;
  localparam logic [6:0] SEG7_D = 7'h5E;
  localparam logic [6:0] SEG7_E = 7'h79;
  localparam logic [6:0] SEG7_F = 7'h71;

endpackage

`default_nettype wire

// File: rtl/dmemory_io_multi_seg7.sv
// ============================================================================
//  Module  : seg7_decode
//  Purpose : Combinational hex nibble to 7-segment pattern decoder.
//  Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module seg7_decode
  import dmem_io_pkg::*;
(
  input  logic [3:0] i_val,
  output logic [6:0] o_seg
);

  logic [6:0] w_seg;

  // Map each nibble value to its segment pattern
  always_comb begin
    w_seg = SEG7_0;
    case (i_val)
      4'h0: w_seg = SEG7_0;
      4'h1: w_seg = SEG7_1;
      4'h2: w_seg = SEG7_2;
      4'h3: w_seg = SEG7_3;
      4'h4: w_seg = SEG7_4;
      4'h5: w_seg = SEG7_5;
      4'h6: w_seg = SEG7_6;
      4'h7: w_seg = SEG7_7;
      4'h8: w_seg = SEG7_8;
      4'h9: w_seg = SEG7_9;
      4'hA: w_seg = SEG7_A;
      4'hB: w_seg = SEG7_B;
      4'hC: w_seg = SEG7_C;
      4'hD: w_seg = SEG7_D;
      4'hE: w_seg = SEG7_E;
      4'hF: w_seg = SEG7_F;
      default: w_seg = SEG7_0;
    endcase
  end

  assign o_seg = w_seg;

endmodule

`default_nettype wire

// File: rtl/dmemory_io_multi.sv
// ============================================================================
//  Module  : dmemory_io_multi
//  Purpose : Word-addressed data RAM plus memory-mapped I/O: NUM_SW
//            synchronised switches with sticky rising-edge flags and
//            NUM_DISP 7-segment display registers.
//  Config  : define DMEM_IO_TIMER_EN to add the free-running TIMER/TCTRL
//            registers at IO_BASE+8 / IO_BASE+9.
//  Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module dmemory_io_multi
  import dmem_io_pkg::*;
#(
  parameter int                DATA_W    = 16,
  parameter int                ADDR_W    = 16,
  parameter int                MEM_DEPTH = 32,
  parameter int                NUM_SW    = 2,
  parameter int                NUM_DISP  = 2,
  parameter logic [ADDR_W-1:0] IO_BASE   = ADDR_W'(16'h00F0)
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [ADDR_W-1:0]     draddr,
  input  logic [DATA_W-1:0]     dwdata,
  input  logic                  dwrite,
  input  logic                  dread,
  output logic [DATA_W-1:0]     drdata,
  input  logic [NUM_SW-1:0]     io_sw,
  output logic [7*NUM_DISP-1:0] io_display
);

  localparam int RAM_AW = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;

  localparam logic [ADDR_W-1:0] C_MEM_END = ADDR_W'(MEM_DEPTH);
  localparam logic [ADDR_W-1:0] C_A_STAT  = IO_BASE + ADDR_W'(SW_STAT_OFS);
  localparam logic [ADDR_W-1:0] C_A_EVT   = IO_BASE + ADDR_W'(SW_EVT_OFS);

  // --------------------------------------------------------------------------
  // Address decode (full-width compares)
  // --------------------------------------------------------------------------
  logic              w_ram_hit;
  logic [RAM_AW-1:0] w_ram_idx;
  logic              w_stat_hit;
  logic              w_evt_hit;
  logic [NUM_DISP-1:0] w_disp_hit;

  assign w_ram_hit  = (draddr < C_MEM_END);
  assign w_ram_idx  = draddr[RAM_AW-1:0];
  assign w_stat_hit = (draddr == C_A_STAT);
  assign w_evt_hit  = (draddr == C_A_EVT);

  // --------------------------------------------------------------------------
  // RAM: not reset, combinational read
  // --------------------------------------------------------------------------
  logic [DATA_W-1:0] r_mem [MEM_DEPTH];

  // Store write data on the clock edge when the address falls in the RAM range
  always_ff @(posedge clock) begin
    if (dwrite && w_ram_hit) begin
      r_mem[w_ram_idx] <= dwdata;
    end
  end

  // --------------------------------------------------------------------------
  // Switches: two-flop synchroniser, previous-value register, sticky flags
  // --------------------------------------------------------------------------
  logic [NUM_SW-1:0] r_sync1;
  logic [NUM_SW-1:0] r_sync2;
  logic [NUM_SW-1:0] r_prev;
  logic [NUM_SW-1:0] r_evt;
  logic [NUM_SW-1:0] w_rise;
  logic              w_evt_clr;

  assign w_rise    = r_sync2 & ~r_prev;
  assign w_evt_clr = dread && w_evt_hit;

  // Synchronise switches and latch rising edges; a new edge beats a read-clear
  always_ff @(posedge clock) begin
    if (reset) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
      r_prev  <= '0;
      r_evt   <= '0;
    end else begin
      r_sync1 <= io_sw;
      r_sync2 <= r_sync1;
      r_prev  <= r_sync2;
      r_evt   <= (w_evt_clr ? '0 : r_evt) | w_rise;
    end
  end

  // --------------------------------------------------------------------------
  // Display registers and decoders
  // --------------------------------------------------------------------------
  logic [3:0] r_disp [NUM_DISP];

  generate
    for (genvar k = 0; k < NUM_DISP; k++) begin : g_disp
      assign w_disp_hit[k] = (draddr == IO_BASE + ADDR_W'(DISP_OFS + k));

      seg7_decode u_seg7 (
        .i_val (r_disp[k]),
        .o_seg (io_display[7*k +: 7])
      );
    end
  endgenerate

  // Each display keeps the low nibble of the last word written to it
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int k = 0; k < NUM_DISP; k++) begin
        r_disp[k] <= 4'h0;
      end
    end else begin
      for (int k = 0; k < NUM_DISP; k++) begin
        if (dwrite && w_disp_hit[k]) begin
          r_disp[k] <= dwdata[3:0];
        end
      end
    end
  end

`ifdef DMEM_IO_TIMER_EN
  // --------------------------------------------------------------------------
  // Optional free-running timer
  // --------------------------------------------------------------------------
  localparam logic [ADDR_W-1:0] C_A_TIMER = IO_BASE + ADDR_W'(TIMER_OFS);
  localparam logic [ADDR_W-1:0] C_A_TCTRL = IO_BASE + ADDR_W'(TCTRL_OFS);

  logic [DATA_W-1:0] r_timer;
  logic              r_run;
  logic              w_timer_hit;
  logic              w_tctrl_hit;
  logic              w_tctrl_wr;

  assign w_timer_hit = (draddr == C_A_TIMER);
  assign w_tctrl_hit = (draddr == C_A_TCTRL);
  assign w_tctrl_wr  = dwrite && w_tctrl_hit;

  // Count while running; the self-clearing clear bit overrides counting
  always_ff @(posedge clock) begin
    if (reset) begin
      r_timer <= '0;
      r_run   <= 1'b0;
    end else begin
      if (w_tctrl_wr) begin
        r_run <= dwdata[0];
      end
      if (w_tctrl_wr && dwdata[1]) begin
        r_timer <= '0;
      end else if (r_run) begin
        r_timer <= r_timer + DATA_W'(1);
      end
    end
  end
`endif

  // --------------------------------------------------------------------------
  // Read multiplexer: unmapped addresses return zero
  // --------------------------------------------------------------------------
  logic [DATA_W-1:0] w_rdata;

  // Select the addressed register or RAM word, zero-extended
  always_comb begin
    w_rdata = '0;
    if (w_ram_hit) begin
      w_rdata = r_mem[w_ram_idx];
    end else if (w_stat_hit) begin
      w_rdata[NUM_SW-1:0] = r_sync2;
    end else if (w_evt_hit) begin
      w_rdata[NUM_SW-1:0] = r_evt;
    end else begin
      for (int k = 0; k < NUM_DISP; k++) begin
        if (w_disp_hit[k]) begin
          w_rdata[3:0] = r_disp[k];
        end
      end
`ifdef DMEM_IO_TIMER_EN
      if (w_timer_hit) begin
        w_rdata = r_timer;
      end else if (w_tctrl_hit) begin
        w_rdata[0] = r_run;
      end
`endif
    end
  end

  assign drdata = w_rdata;

endmodule

`default_nettype wire

// File: tb/tb_dmemory_io_multi.sv
// ============================================================================
//  Module  : tb_dmemory_io_multi
//  Purpose : Self-checking bench for dmemory_io_multi (default parameters)
//            with directed steps and randomised traffic against a
//            history-based reference model.
//  Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_dmemory_io_multi;

  localparam logic [15:0] BASE = 16'h00F0;

  logic        clock;
  logic        reset;
  logic [15:0] draddr;
  logic [15:0] dwdata;
  logic        dwrite;
  logic        dread;
  logic [15:0] drdata;
  logic [1:0]  io_sw;
  logic [13:0] io_display;

  int n_checks = 0;
  int n_fail   = 0;

  dmemory_io_multi dut (
    .clock      (clock),
    .reset      (reset),
    .draddr     (draddr),
    .dwdata     (dwdata),
    .dwrite     (dwrite),
    .dread      (dread),
    .drdata     (drdata),
    .io_sw      (io_sw),
    .io_display (io_display)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // ---------------- reference model ----------------
  logic [6:0]  seg_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
  logic [15:0] m_mem  [32];
  bit          m_val  [32];
  logic [1:0]  h      [4];   // h[0] = switch value sampled at the latest edge, h[1] the one before...
  logic [1:0]  m_evt;
  logic [3:0]  m_disp [2];
  logic [15:0] m_timer;
  logic        m_run;

  task automatic model_edge();
    logic [1:0] rise;
    logic       twr;
    if (dwrite && draddr < 16'd32) begin
      m_mem[draddr[4:0]] = dwdata;
      m_val[draddr[4:0]] = 1'b1;
    end
    if (reset) begin
      for (int i = 0; i < 4; i++) h[i] = 2'b00;
      m_evt = 2'b00; m_disp[0] = 4'h0; m_disp[1] = 4'h0;
      m_timer = 16'h0; m_run = 1'b0;
    end else begin
      rise = h[1] & ~h[2];
      if (dread && draddr == BASE + 16'd1) m_evt = 2'b00;
      m_evt = m_evt | rise;
      if (dwrite && draddr == BASE + 16'd2) m_disp[0] = dwdata[3:0];
      if (dwrite && draddr == BASE + 16'd3) m_disp[1] = dwdata[3:0];
`ifdef DMEM_IO_TIMER_EN
      twr = dwrite && draddr == BASE + 16'd9;
      if (twr && dwdata[1]) m_timer = 16'h0;
      else if (m_run)       m_timer = m_timer + 16'd1;
      if (twr) m_run = dwdata[0];
`else
      twr = 1'b0;
`endif
      h[3] = h[2]; h[2] = h[1]; h[1] = h[0]; h[0] = io_sw;
    end
  endtask

  function automatic logic [15:0] exp_rd(input logic [15:0] a, output bit known);
    known = 1'b1;
    if (a < 16'd32) begin
      known = m_val[a[4:0]];
      return m_mem[a[4:0]];
    end
    if (a == BASE)          return {14'b0, h[1]};
    if (a == BASE + 16'd1)  return {14'b0, m_evt};
    if (a == BASE + 16'd2)  return {12'b0, m_disp[0]};
    if (a == BASE + 16'd3)  return {12'b0, m_disp[1]};
`ifdef DMEM_IO_TIMER_EN
    if (a == BASE + 16'd8)  return m_timer;
    if (a == BASE + 16'd9)  return {15'b0, m_run};
`endif
    return 16'h0000;
  endfunction

  // ---------------- helpers ----------------
  task automatic step();
    @(posedge clock);
    model_edge();
    #1;
  endtask

  task automatic drive(input logic [15:0] a, input logic [15:0] d, input logic we, input logic re);
    draddr = a; dwdata = d; dwrite = we; dread = re;
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_rd(input string tag);
    bit          k;
    logic [15:0] e;
    e = exp_rd(draddr, k);
    if (k) chk(tag, {16'b0, drdata}, {16'b0, e});
  endtask

  task automatic chk_disp(input string tag);
    chk(tag, {18'b0, io_display}, {18'b0, seg_tab[m_disp[1]], seg_tab[m_disp[0]]});
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [15:0] a;
    logic [15:0] ra [20];

    reset = 1'b1; io_sw = 2'b00;
    draddr = '0; dwdata = '0; dwrite = 1'b0; dread = 1'b0;
    for (int i = 0; i < 32; i++) m_val[i] = 1'b0;
    for (int i = 0; i < 3; i++) step();
    reset = 1'b0;

    // Reset state
    drive(BASE, 0, 0, 0);         chk("rst_stat", {16'b0, drdata}, 32'h0);
    drive(BASE + 16'd1, 0, 0, 0); chk("rst_evt",  {16'b0, drdata}, 32'h0);
    drive(BASE + 16'd2, 0, 0, 0); chk("rst_disp", {16'b0, drdata}, 32'h0);
    chk("rst_display", {18'b0, io_display}, {18'b0, 7'h3F, 7'h3F});

    // RAM directed
    drive(16'd5, 16'h1234, 1, 0); step();
    drive(16'd6, 16'h00FF, 1, 0); step();
    drive(16'd5, 0, 0, 0); chk("ram5", {16'b0, drdata}, 32'h1234);
    drive(16'd6, 0, 0, 0); chk("ram6", {16'b0, drdata}, 32'h00FF);

    // RAM random write then read-back
    for (int i = 0; i < 20; i++) begin
      ra[i] = 16'($urandom_range(0, 31));
      drive(ra[i], 16'($urandom), 1, 0); step();
    end
    for (int i = 0; i < 20; i++) begin
      drive(ra[19 - i], 0, 0, 0); chk_rd("ram_rand");
    end

    // Switch latency and sticky flag
    drive(BASE, 0, 0, 0);
    io_sw = 2'b01;
    step(); chk("sw_stat_e1", {16'b0, drdata}, 32'h0);
    step(); chk("sw_stat_e2", {16'b0, drdata}, 32'h1);
    drive(BASE + 16'd1, 0, 0, 0); chk("sw_evt_e2", {16'b0, drdata}, 32'h0);
    step(); chk("sw_evt_e3", {16'b0, drdata}, 32'h1);
    step(); chk("sw_evt_sticky", {16'b0, drdata}, 32'h1);
    drive(BASE + 16'd1, 0, 0, 1); chk("sw_evt_preclr", {16'b0, drdata}, 32'h1);
    step();
    drive(BASE + 16'd1, 0, 0, 0); chk("sw_evt_cleared", {16'b0, drdata}, 32'h0);

    // Edge on sw1 coincides with read-clear: edge wins
    io_sw = 2'b11;
    step(); step();
    drive(BASE + 16'd1, 0, 0, 1); chk_rd("race_pre");
    step();
    drive(BASE + 16'd1, 0, 0, 0); chk("race_evt", {16'b0, drdata}, 32'h2);

    // Display
    drive(BASE + 16'd2, 16'h000A, 1, 0); step();
    drive(BASE + 16'd2, 0, 0, 0);
    chk("disp0_seg", {25'b0, io_display[6:0]}, 32'h77);
    chk("disp0_rd",  {16'b0, drdata}, 32'h000A);
    drive(BASE + 16'd3, 16'hFFF3, 1, 0); step();
    drive(BASE + 16'd3, 0, 0, 0);
    chk("disp1_rd", {16'b0, drdata}, 32'h0003);
    chk("disp_both", {18'b0, io_display}, {18'b0, 7'h4F, 7'h77});

    // Unmapped and read-only writes
    drive(BASE + 16'd5, 16'hBEEF, 1, 0); step();
    drive(BASE, 16'hBEEF, 1, 0); step();
    drive(BASE + 16'd5, 0, 0, 0); chk("unmapped_rd", {16'b0, drdata}, 32'h0);
    drive(BASE, 0, 0, 0);         chk("ro_stat_rd",  {16'b0, drdata}, 32'h3);
    drive(BASE + 16'd1, 16'hFFFF, 1, 0); step();
    drive(BASE + 16'd1, 0, 0, 0); chk("ro_evt_rd", {16'b0, drdata}, 32'h2);
    drive(16'h80F0, 0, 0, 0);     chk("alias_high", {16'b0, drdata}, 32'h0);
    chk_disp("disp_after_ro");

    // Randomised mixed traffic against the model
    for (int i = 0; i < 300; i++) begin
      case ($urandom_range(0, 3))
        0: a = 16'($urandom_range(0, 31));
        1: a = BASE + 16'($urandom_range(0, 9));
        2: a = 16'($urandom);
        default: a = BASE + 16'd1;
      endcase
      if ($urandom_range(0, 3) == 0) io_sw = 2'($urandom);
      drive(a, 16'($urandom), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      chk_rd("rand_rd");
      step();
      chk_disp("rand_disp");
    end

    // Timer
`ifdef DMEM_IO_TIMER_EN
    drive(BASE + 16'd9, 16'h0002, 1, 0); step();
    drive(BASE + 16'd9, 16'h0001, 1, 0); step();
    drive(BASE + 16'd8, 0, 0, 0);
    for (int i = 0; i < 10; i++) step();
    chk("timer_10", {16'b0, drdata}, 32'd10);
    drive(BASE + 16'd9, 0, 0, 0); chk("tctrl_rd", {16'b0, drdata}, 32'h1);
    drive(BASE + 16'd9, 16'h0003, 1, 0); step();
    drive(BASE + 16'd8, 0, 0, 0); chk("timer_clr", {16'b0, drdata}, 32'h0);
    step(); chk("timer_after_clr", {16'b0, drdata}, 32'h1);
    drive(BASE + 16'd9, 16'h0000, 1, 0); step();
    drive(BASE + 16'd8, 0, 0, 0); chk_rd("timer_stop");
`else
    drive(BASE + 16'd8, 16'h1234, 1, 0); step();
    drive(BASE + 16'd8, 0, 0, 0); chk("timer_absent", {16'b0, drdata}, 32'h0);
    drive(BASE + 16'd9, 0, 0, 0); chk("tctrl_absent", {16'b0, drdata}, 32'h0);
`endif

    // Reset mid-access, switch held high through reset
    io_sw = 2'b01;
    drive(BASE + 16'd2, 16'h0005, 1, 0);
    reset = 1'b1;
    step();
    drive(BASE + 16'd2, 0, 0, 0);
    step();
    reset = 1'b0;
    chk("rst_mid_display", {18'b0, io_display}, {18'b0, 7'h3F, 7'h3F});
    chk("rst_mid_disp_rd", {16'b0, drdata}, 32'h0);
    drive(BASE + 16'd1, 0, 0, 0);
    chk("rst_mid_evt", {16'b0, drdata}, 32'h0);
    step(); step();
    chk("rst_evt_e2", {16'b0, drdata}, 32'h0);
    step();
    chk("rst_evt_e3", {16'b0, drdata}, 32'h1);
    chk_rd("rst_evt_model");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
